// File: rtl/sram_sp_arb_if.sv
// Two-master request/ack bus plus the single-port SRAM control bus seen by the arbiter.
// The master modport is the environment side: both requesters and the SRAM itself.
interface sram_sp_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          m0_req,   m1_req;
  logic          m0_we,    m1_we;
  logic [AW-1:0] m0_addr,  m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_sel,   m1_sel;
  logic          m0_ack,   m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;

  logic          sram_ce, sram_we, sram_oe;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [SW-1:0] sram_sel;
  logic [DW-1:0] sram_dout;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_sel, m1_sel, sram_dout,
    output m0_ack, m1_ack, m0_rdata, m1_rdata,
           sram_ce, sram_we, sram_oe, sram_addr, sram_din, sram_sel
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_sel, m1_sel, sram_dout,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata,
           sram_ce, sram_we, sram_oe, sram_addr, sram_din, sram_sel
  );
endinterface

// File: rtl/sram_sp_arb.sv
// Round-robin arbiter sharing one single-port SRAM between two masters.
// Fixed 3-cycle access: IDLE (arbitrate) -> ACCESS (SRAM strobed) -> RESP (ack).
module sram_sp_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           rst,
  sram_sp_arb_if.slave  bus
);
  localparam int SW = DW / 8;
  localparam int NM = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [NM-1:0]         req, we, ack;
  logic [NM-1:0][AW-1:0] addr;
  logic [NM-1:0][DW-1:0] wdata, rdata;
  logic [NM-1:0][SW-1:0] sel;

  logic          prio, grant, win, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [SW-1:0] sel_q;
  logic          access, resp, arb;

  assign req   = {bus.m1_req,   bus.m0_req};
  assign we    = {bus.m1_we,    bus.m0_we};
  assign addr  = {bus.m1_addr,  bus.m0_addr};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};
  assign sel   = {bus.m1_sel,   bus.m0_sel};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win       = req[prio] ? prio : ~prio;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign arb    = (state == IDLE) && (|req);
  assign access = (state == ACCESS);
  assign resp   = (state == RESP);

  // Winner's request is captured once; master inputs are don't-care until the next IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio   <= 1'b0;
      grant  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      sel_q  <= '0;
    end else if (arb) begin
      grant  <= win;
      prio   <= ~win;
      we_q   <= we[win];
      addr_q <= addr[win];
      din_q  <= wdata[win];
      sel_q  <= sel[win];
    end
  end

  // Strobes derive from state so an async reset drops them without a clock.
  assign bus.sram_ce   = access;
  assign bus.sram_we   = access & we_q;
  assign bus.sram_oe   = access & ~we_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = din_q;
  assign bus.sram_sel  = sel_q;

  for (genvar i = 0; i < NM; i++) begin : g_resp
    assign ack[i]   = resp && (grant == 1'(i));
    assign rdata[i] = (ack[i] && !we_q) ? bus.sram_dout : '0;
  end

  assign bus.m0_ack   = ack[0];
  assign bus.m1_ack   = ack[1];
  assign bus.m0_rdata = rdata[0];
  assign bus.m1_rdata = rdata[1];
endmodule

// File: tb/tb_sram_sp_arb.sv
// Bench for sram_sp_arb: behavioural SRAM, reference memory/priority model, randomized accesses.
module tb_sram_sp_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_sp_arb_if #(.AW(AW), .DW(DW)) bus ();
  sram_sp_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack = 0;
  bit exp_prio = 1'b0;

  logic [31:0] smem [256] = '{default: 32'h0};
  logic [31:0] rmem [256] = '{default: 32'h0};

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAM: read data appears one cycle after the strobed cycle.
  always @(posedge clk) begin
    if (bus.sram_ce) begin
      if (bus.sram_we) smem[bus.sram_addr[7:0]] <= merge(smem[bus.sram_addr[7:0]], bus.sram_din, bus.sram_sel);
      else             bus.sram_dout <= smem[bus.sram_addr[7:0]];
    end
  end

  function automatic logic ackof(input int m);
    return (m == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction

  function automatic logic [31:0] rdof(input int m);
    return (m == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction

  task automatic set_m(input int m, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_sel = s;
    end else begin
      bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_sel = s;
    end
  endtask

  // One lone access from master m, checking bus strobes, latency and response.
  task automatic do_access(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit got;
    got = 1'b0;
    rd = '0;
    exp_rd = w ? 32'h0 : rmem[a[7:0]];
    @(negedge clk);
    set_m(m, 1'b1, w, a, d, s);
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if ({bus.sram_ce, bus.sram_we, bus.sram_oe} !== {1'b1, w, ~w}) begin
          n_err++; $display("FAIL access_ctrl m%0d: ce/we/oe=%b%b%b want 1%b%b", m,
                            bus.sram_ce, bus.sram_we, bus.sram_oe, w, ~w);
        end
        n_cmp++;
        if (bus.sram_addr !== a || bus.sram_sel !== s || (w && bus.sram_din !== d)) begin
          n_err++; $display("FAIL access_bus m%0d: addr=%h sel=%h din=%h want %h %h %h", m,
                            bus.sram_addr, bus.sram_sel, bus.sram_din, a, s, d);
        end
      end
      if (bus.m0_ack || bus.m1_ack) begin
        got = 1'b1;
        n_cmp++;
        if (k != 2) begin n_err++; $display("FAIL latency m%0d: ack after %0d cycles want 2", m, k); end
        n_cmp++;
        if (ackof(m) !== 1'b1 || ackof(1 - m) !== 1'b0) begin
          n_err++; $display("FAIL ack_owner: m0_ack=%b m1_ack=%b want only m%0d", bus.m0_ack, bus.m1_ack, m);
        end
        rd = rdof(m);
        n_cmp++;
        if (rd !== exp_rd || rdof(1 - m) !== 32'h0) begin
          n_err++; $display("FAIL rdata m%0d: got %h other %h want %h other 0", m, rd, rdof(1 - m), exp_rd);
        end
      end
    end
    if (!got) begin n_cmp++; n_err++; $display("FAIL ack_timeout m%0d: no ack within 8 cycles", m); end
    set_m(m, 1'b0, 1'b0, '0, '0, '0);
    if (w) rmem[a[7:0]] = merge(rmem[a[7:0]], d, s);
    exp_prio = (m == 0);
    last_ack = cyc;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    set_m(0, 1'b1, 1'b1, 32'h3, 32'h55, 4'hF);
    set_m(1, 1'b1, 1'b0, 32'h4, 32'h66, 4'hF);
    #1;
    n_cmp++;
    if ({bus.sram_ce, bus.sram_we, bus.sram_oe, bus.m0_ack, bus.m1_ack} !== 5'b0 ||
        bus.sram_addr !== 32'h0 || bus.sram_din !== 32'h0 || bus.sram_sel !== 4'h0) begin
      n_err++; $display("FAIL reset_outputs: ce/we/oe/ack=%b%b%b%b%b addr=%h din=%h sel=%h want all 0",
                        bus.sram_ce, bus.sram_we, bus.sram_oe, bus.m0_ack, bus.m1_ack,
                        bus.sram_addr, bus.sram_din, bus.sram_sel);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.sram_ce !== 1'b0 || bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_hold: ce=%b rdata=%h/%h want 0 while reset low", bus.sram_ce, bus.m0_rdata, bus.m1_rdata);
    end
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    exp_prio = 1'b0;
    repeat (2) @(negedge clk);
    do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    repeat (3) @(negedge clk);
    do_access(1, 1'b0, 32'h10, 32'h0, 4'hF, rd);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL reset_readback: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_sel();
    logic [31:0] rd;
    do_access(0, 1'b1, 32'h4, 32'h11223344, 4'hF, rd);
    do_access(1, 1'b1, 32'h4, 32'h000000AA, 4'h1, rd);
    do_access(0, 1'b0, 32'h4, 32'h0, 4'hF, rd);
    n_cmp++;
    if (rd !== 32'h112233AA) begin n_err++; $display("FAIL byte_sel: got %h want 112233aa", rd); end
  endtask

  // Both masters hold req continuously; grants must alternate with acks 3 cycles apart.
  task automatic test_contention(input int n);
    bit          w [2];
    logic [31:0] a [2], d [2];
    logic [3:0]  s [2];
    int start, prev, win;
    bit got;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      w[m] = 1'($urandom_range(0, 1)); a[m] = $urandom_range(0, 15);
      d[m] = $urandom; s[m] = 4'($urandom_range(1, 15));
      set_m(m, 1'b1, w[m], a[m], d[m], s[m]);
    end
    start = cyc; prev = cyc;
    for (int i = 0; i < n; i++) begin
      win = int'(exp_prio);
      got = 1'b0;
      for (int k = 1; k <= 6 && !got; k++) begin
        @(negedge clk);
        if (bus.m0_ack || bus.m1_ack) got = 1'b1;
      end
      if (!got) begin n_cmp++; n_err++; $display("FAIL contention_timeout: access %0d", i); break; end
      n_cmp++;
      if (ackof(win) !== 1'b1 || ackof(1 - win) !== 1'b0) begin
        n_err++; $display("FAIL contention_grant %0d: m0_ack=%b m1_ack=%b want m%0d", i, bus.m0_ack, bus.m1_ack, win);
      end
      n_cmp++;
      if ((i == 0 && cyc - start != 2) || (i > 0 && cyc - prev != 3)) begin
        n_err++; $display("FAIL contention_gap %0d: %0d cycles want %0d", i, cyc - prev, (i == 0) ? 2 : 3);
      end
      n_cmp++;
      if (rdof(win) !== (w[win] ? 32'h0 : rmem[a[win][7:0]]) || rdof(1 - win) !== 32'h0) begin
        n_err++; $display("FAIL contention_rdata %0d: got %h want %h", i, rdof(win), w[win] ? 32'h0 : rmem[a[win][7:0]]);
      end
      if (w[win]) rmem[a[win][7:0]] = merge(rmem[a[win][7:0]], d[win], s[win]);
      prev = cyc;
      exp_prio = (win == 0);
      w[win] = 1'($urandom_range(0, 1)); a[win] = $urandom_range(0, 15);
      d[win] = $urandom; s[win] = 4'($urandom_range(1, 15));
      set_m(win, 1'b1, w[win], a[win], d[win], s[win]);
    end
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    last_ack = cyc;
  endtask

  task automatic test_lone();
    logic [31:0] rd;
    int prev;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      prev = last_ack;
      do_access(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom_range(1, 15)), rd);
      if (i > 0) begin
        n_cmp++;
        if (last_ack - prev != 3) begin n_err++; $display("FAIL lone_gap %0d: %0d cycles want 3", i, last_ack - prev); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] old0, nd;
    int c0;
    bit any_ack, got;
    old0 = rmem[8'h20];
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    n_cmp++;
    if (bus.sram_ce !== 1'b1) begin n_err++; $display("FAIL midrst_pre: ce=%b want 1 in access", bus.sram_ce); end
    c0 = cyc;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.sram_ce !== 1'b0 || bus.sram_we !== 1'b0 || cyc != c0) begin
      n_err++; $display("FAIL midrst_async: ce=%b we=%b edges=%0d want 0 0 0", bus.sram_ce, bus.sram_we, cyc - c0);
    end
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    any_ack = 1'b0;
    repeat (3) begin @(negedge clk); any_ack |= bus.m0_ack | bus.m1_ack; end
    rst = 1'b1;
    exp_prio = 1'b0;
    repeat (2) begin @(negedge clk); any_ack |= bus.m0_ack | bus.m1_ack; end
    n_cmp++;
    if (any_ack) begin n_err++; $display("FAIL midrst_noack: ack seen for aborted access"); end
    nd = $urandom;
    set_m(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 32'h24, nd, 4'hF);
    got = 1'b0;
    for (int k = 1; k <= 6 && !got; k++) begin @(negedge clk); got = bus.m0_ack | bus.m1_ack; end
    n_cmp++;
    if (bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0 || bus.m0_rdata !== old0) begin
      n_err++; $display("FAIL midrst_first: acks=%b%b rdata=%h want m0 with %h", bus.m1_ack, bus.m0_ack, bus.m0_rdata, old0);
    end
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    got = 1'b0;
    for (int k = 1; k <= 6 && !got; k++) begin @(negedge clk); got = bus.m0_ack | bus.m1_ack; end
    n_cmp++;
    if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0) begin
      n_err++; $display("FAIL midrst_second: acks m1/m0=%b%b want 10", bus.m1_ack, bus.m0_ack);
    end
    rmem[8'h24] = nd;
    exp_prio = 1'b0;
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    last_ack = cyc;
  endtask

  task automatic test_withdraw();
    logic [31:0] rd;
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clk);
    n_cmp++;
    if (bus.sram_ce !== 1'b1 || bus.sram_oe !== 1'b1) begin
      n_err++; $display("FAIL withdraw_access: ce=%b oe=%b want 1 1", bus.sram_ce, bus.sram_oe);
    end
    bus.m0_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.m0_ack !== 1'b1 || bus.m0_rdata !== rmem[8'h10] || bus.sram_oe !== 1'b0) begin
      n_err++; $display("FAIL withdraw_ack: ack=%b rdata=%h oe=%b want 1 %h 0", bus.m0_ack, bus.m0_rdata, bus.sram_oe, rmem[8'h10]);
    end
    n_cmp++;
    if (bus.sram_addr !== 32'h10) begin n_err++; $display("FAIL addr_retain: got %h want 10", bus.sram_addr); end
    @(negedge clk);
    n_cmp++;
    if (bus.m0_ack !== 1'b0 || bus.m0_rdata !== 32'h0) begin
      n_err++; $display("FAIL ack_one_cycle: ack=%b rdata=%h want 0 0", bus.m0_ack, bus.m0_rdata);
    end
    exp_prio = 1'b1;
    do_access(0, 1'b1, 32'h11, $urandom, 4'hF, rd);
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++)
      do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                $urandom, 4'($urandom_range(1, 15)), rd);
  endtask

  initial begin
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    test_reset();
    test_contention(4);
    test_byte_sel();
    test_lone();
    test_reset_mid();
    test_withdraw();
    test_contention(6);
    test_random(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_sp_arb.md
SRAM_SP_ARB -- requirements
Module: sram_sp_arb

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width in bits; legal values are 8, 16 and 32.
REQ-003 The block SHALL have localparam SW = DW/8, meaning byte-select width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have ports m0_req, m1_req, input, 1 bit each: access request from master 0 and master 1.
REQ-007 The block SHALL have ports m0_we, m1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports m0_addr, m1_addr, input, AW bits each: word address.
REQ-009 The block SHALL have ports m0_wdata, m1_wdata, input, DW bits each: write data.
REQ-010 The block SHALL have ports m0_sel, m1_sel, input, SW bits each: byte selects.
REQ-011 The block SHALL have ports m0_ack, m1_ack, output, 1 bit each: one-cycle completion strobe.
REQ-012 The block SHALL have ports m0_rdata, m1_rdata, output, DW bits each: read data, valid while the matching ack is 1.
REQ-013 The block SHALL have ports sram_ce, sram_we, sram_oe, output, 1 bit each: controls to the single-port SRAM.
REQ-014 The block SHALL have ports sram_addr (AW bits), sram_din (DW bits) and sram_sel (SW bits), outputs: address, write data and byte selects to the SRAM.
REQ-015 The block SHALL have port sram_dout, input, DW bits: SRAM read data, valid one cycle after an access cycle.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when any req is 1, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-017 In IDLE, the winner SHALL be master prio if its req is 1, otherwise the other master; the winner is registered as grant.
REQ-018 On the IDLE->ACCESS transition, prio SHALL become the non-winning master, giving strict round-robin alternation under continuous contention.
REQ-019 On the IDLE->ACCESS edge, the block SHALL register the winner's we, addr, wdata and sel into sram_we, sram_addr, sram_din and sram_sel.
REQ-020 In ACCESS, sram_ce SHALL be 1 and sram_oe SHALL be ~sram_we; in every other state, sram_ce, sram_we and sram_oe SHALL be 0.
REQ-021 In RESP, mX_ack SHALL be 1 for the granted master only, for exactly one cycle.
REQ-022 In RESP, mX_rdata of the granted master SHALL equal sram_dout (combinational) for a read and 0 for a write; rdata SHALL be 0 outside RESP and for the non-granted master.
REQ-023 Latency SHALL be fixed: a request sampled in IDLE at cycle N is driven to the SRAM in cycle N+1 and acked in cycle N+2; peak throughput is one access per 3 cycles.
REQ-024 A master SHALL hold req and its fields stable until ack, and SHALL drop req in the cycle after ack; a req still high in IDLE after that is treated as a new access.
REQ-025 A req deasserted during ACCESS or RESP SHALL NOT abort the access; it completes and is acked.
REQ-026 Master inputs SHALL be ignored outside IDLE; a losing master's request is held off until the next IDLE.
REQ-027 sram_addr, sram_din and sram_sel SHALL retain their last values outside ACCESS.

Reset
REQ-028 While rst = 0, the block SHALL immediately hold state = IDLE, prio = 0, grant = 0, all sram_* outputs = 0, and all acks and rdata = 0.
REQ-029 A reset asserted during ACCESS SHALL drop sram_ce asynchronously, and no ack SHALL be issued for that access.
REQ-030 After rst rises, the first arbitration SHALL occur at the first rising clk edge at which some req is 1.

Verification
REQ-031 Reset scenario: reset, then m0 writes addr 0x10 with data 0xDEADBEEF and sel 0xF; later m1 reads 0x10 -> m0_ack at cycle +2, then m1_ack with m1_rdata = 0xDEADBEEF.
REQ-032 Contention scenario: m0_req and m1_req are both held high for 4 accesses -> grants are 0,1,0,1, the acks never overlap, and acks are 3 cycles apart.
REQ-033 Byte-select scenario: write 0x11223344 to 0x4 with sel 0xF, then write 0x000000AA with sel 0x1, then read 0x4 -> read returns 0x112233AA.
REQ-034 Lone-requester scenario: only m1 requests, 3 back-to-back accesses -> all are granted to m1, and prio does not block m1.
REQ-035 Reset-mid-access scenario: rst is pulled low during ACCESS of a write -> sram_ce falls without waiting for clk, no ack is issued, and after release the first arbitration picks m0 when both request.
REQ-036 Withdrawn-request scenario: m0 drops req during ACCESS -> m0_ack is still pulsed in RESP, and sram_oe = 1 only in ACCESS for reads.
